// File: rtl/uart_pic_loader.sv
// Framed image loader: hunts for a 55 AA header in the UART FIFO, validates the
// window, programs CASET/RASET/RAMWR and streams pixel bytes to the LCD writer.
module uart_pic_loader #(
  parameter int unsigned H_PIX       = 240,
  parameter int unsigned V_PIX       = 320,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       init_done,
  input  logic       wr_done,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rdEn,
  output logic [8:0] show_pic_data,
  output logic       en_write_show_pic,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HUNT0 = 3'd1;
  localparam logic [2:0] S_HUNT1 = 3'd2;
  localparam logic [2:0] S_HDR   = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [2:0] S_PIX   = 3'd6;

  localparam logic [9:0] H_LIM = H_PIX[9:0];
  localparam logic [9:0] V_LIM = V_PIX[9:0];

  logic [2:0]  state_q, state_d;
  logic        rd_en_q, rd_en_d;
  logic        byte_vld_q;
  logic        wr_busy_q, wr_busy_d;
  logic        strobe_q, strobe_d;
  logic [8:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [3:0]  win_idx_q, win_idx_d;
  logic [8:0]  xs_q, xs_d, ys_q, ys_d, w_q, w_d, h_q, h_d;
  logic [9:0]  xe_q, xe_d, ye_q, ye_d;
  logic [17:0] pix_cnt_q, pix_cnt_d;
  logic [23:0] tmo_q, tmo_d;

  logic [9:0]  xe_calc, ye_calc;
  logic [17:0] pix_total;
  logic        frame_bad;
  logic        need_byte;
  logic        pop;
  logic [8:0]  win_word;

  assign xe_calc   = {1'b0, xs_q} + {1'b0, w_q} - 10'd1;
  assign ye_calc   = {1'b0, ys_q} + {1'b0, h_q} - 10'd1;
  assign pix_total = 18'(w_q) * 18'(h_q) * 18'd2;
  assign frame_bad = (w_q == 9'd0) || (h_q == 9'd0) || (xe_calc >= H_LIM) || (ye_calc >= V_LIM);

  // Only one pop may be outstanding, and never while a word is being shifted out.
  assign need_byte = (state_q == S_HUNT0) || (state_q == S_HUNT1) || (state_q == S_HDR) ||
                     ((state_q == S_PIX) && (pix_cnt_q != 18'd0));
  assign pop       = need_byte && !fifo_empty && !rd_en_q && !byte_vld_q && !wr_busy_q;

  always_comb begin
    win_word = {1'b0, 8'h2C};
    case (win_idx_q)
      4'd0:    win_word = {1'b0, 8'h2A};
      4'd1:    win_word = {1'b1, 7'b0, xs_q[8]};
      4'd2:    win_word = {1'b1, xs_q[7:0]};
      4'd3:    win_word = {1'b1, 6'b0, xe_q[9:8]};
      4'd4:    win_word = {1'b1, xe_q[7:0]};
      4'd5:    win_word = {1'b0, 8'h2B};
      4'd6:    win_word = {1'b1, 7'b0, ys_q[8]};
      4'd7:    win_word = {1'b1, ys_q[7:0]};
      4'd8:    win_word = {1'b1, 6'b0, ye_q[9:8]};
      4'd9:    win_word = {1'b1, ye_q[7:0]};
      default: win_word = {1'b0, 8'h2C};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_en_d   = pop;
    wr_busy_d = wr_busy_q & ~wr_done;
    strobe_d  = 1'b0;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    hdr_idx_d = hdr_idx_q;
    win_idx_d = win_idx_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    w_d       = w_q;
    h_d       = h_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    pix_cnt_d = pix_cnt_q;
    tmo_d     = 24'd0;

    case (state_q)
      S_IDLE: begin
        if (init_done) state_d = S_HUNT0;
      end
      S_HUNT0: begin
        if (byte_vld_q && (fifo_data == 8'h55)) state_d = S_HUNT1;
      end
      S_HUNT1: begin
        if (byte_vld_q) begin
          if (fifo_data == 8'hAA) begin
            state_d   = S_HDR;
            hdr_idx_d = 3'd0;
          end else if (fifo_data != 8'h55) begin
            state_d = S_HUNT0;
          end
        end
      end
      S_HDR: begin
        if (byte_vld_q) begin
          case (hdr_idx_q)
            3'd0:    xs_d[8]   = fifo_data[0];
            3'd1:    xs_d[7:0] = fifo_data;
            3'd2:    ys_d[8]   = fifo_data[0];
            3'd3:    ys_d[7:0] = fifo_data;
            3'd4:    w_d[8]    = fifo_data[0];
            3'd5:    w_d[7:0]  = fifo_data;
            3'd6:    h_d[8]    = fifo_data[0];
            default: h_d[7:0]  = fifo_data;
          endcase
          hdr_idx_d = hdr_idx_q + 3'd1;
          if (hdr_idx_q == 3'd7) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        xe_d = xe_calc;
        ye_d = ye_calc;
        if (frame_bad) begin
          err_d   = 1'b1;
          state_d = S_HUNT0;
        end else begin
          pix_cnt_d = pix_total;
          win_idx_d = 4'd0;
          state_d   = S_WIN;
        end
      end
      S_WIN: begin
        // Stay here until RAMWR itself has completed so its wr_done is not
        // mistaken for a pixel completion.
        if (!wr_busy_q) begin
          if (win_idx_q == 4'd11) begin
            state_d = S_PIX;
          end else begin
            strobe_d  = 1'b1;
            data_d    = win_word;
            wr_busy_d = 1'b1;
            win_idx_d = win_idx_q + 4'd1;
          end
        end
      end
      S_PIX: begin
        if (byte_vld_q) begin
          strobe_d  = 1'b1;
          data_d    = {1'b1, fifo_data};
          wr_busy_d = 1'b1;
        end else if (wr_busy_q && wr_done) begin
          pix_cnt_d = pix_cnt_q - 18'd1;
          if (pix_cnt_q == 18'd1) begin
            done_d  = 1'b1;
            state_d = S_HUNT0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_HDR) || (state_q == S_PIX)) begin
      tmo_d = pop ? 24'd0 : tmo_q + 24'd1;
      if (!pop && !rd_en_q && !byte_vld_q && !done_d && (tmo_q == TIMEOUT_CYC - 24'd1)) begin
        err_d   = 1'b1;
        state_d = S_HUNT0;
        tmo_d   = 24'd0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      rd_en_q    <= 1'b0;
      byte_vld_q <= 1'b0;
      wr_busy_q  <= 1'b0;
      strobe_q   <= 1'b0;
      data_q     <= 9'h000;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hdr_idx_q  <= 3'd0;
      win_idx_q  <= 4'd0;
      xs_q       <= 9'd0;
      ys_q       <= 9'd0;
      w_q        <= 9'd0;
      h_q        <= 9'd0;
      xe_q       <= 10'd0;
      ye_q       <= 10'd0;
      pix_cnt_q  <= 18'd0;
      tmo_q      <= 24'd0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      byte_vld_q <= rd_en_q;
      wr_busy_q  <= wr_busy_d;
      strobe_q   <= strobe_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hdr_idx_q  <= hdr_idx_d;
      win_idx_q  <= win_idx_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      w_q        <= w_d;
      h_q        <= h_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      pix_cnt_q  <= pix_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign fifo_rdEn         = rd_en_q;
  assign show_pic_data     = data_q;
  assign en_write_show_pic = strobe_q;
  assign frame_done        = done_q;
  assign frame_err         = err_q;

endmodule

// File: tb/tb_uart_pic_loader.sv
// Directed bench for uart_pic_loader with a FIFO model, an LCD writer model with
// adjustable wr_done latency, and a protocol monitor.
module tb_uart_pic_loader;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       init_done = 1'b0;
  logic       wr_done;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rdEn;
  logic [8:0] show_pic_data;
  logic       en_write_show_pic;
  logic       frame_done;
  logic       frame_err;

  uart_pic_loader #(.H_PIX(240), .V_PIX(320), .TIMEOUT_CYC(24'd50)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .init_done(init_done),
    .wr_done(wr_done),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rdEn(fifo_rdEn),
    .show_pic_data(show_pic_data),
    .en_write_show_pic(en_write_show_pic),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // FIFO model: data appears the cycle after the pop, flushed while in reset.
  logic [7:0] fmem [0:1023];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (rp == wp);

  always @(posedge sys_clk) begin
    if (!sys_rst_n) rp <= wp;
    else if (fifo_rdEn && (rp != wp)) begin
      fifo_data <= fmem[rp % 1024];
      rp <= rp + 1;
    end
  end

  // LCD writer model: wr_done pulses wr_lat cycles after each strobe.
  int wr_lat = 2;
  int wcnt;
  bit wbusy_m;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_done <= 1'b0;
      wbusy_m <= 1'b0;
      wcnt    <= 0;
    end else begin
      wr_done <= 1'b0;
      if (en_write_show_pic) begin
        wbusy_m <= 1'b1;
        wcnt    <= wr_lat;
      end else if (wbusy_m) begin
        if (wcnt <= 1) begin
          wr_done <= 1'b1;
          wbusy_m <= 1'b0;
        end else wcnt <= wcnt - 1;
      end
    end
  end

  // Monitor: logs words, counts events and protocol violations.
  logic [8:0] wlog [$];
  int cyc = 0, fd_cnt = 0, fe_cnt = 0, viol = 0, pop_cnt = 0, last_pop_cyc = 0, err_cyc = 0;
  bit tbusy = 1'b0;
  logic [8:0] held = 9'h000;
  always @(negedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) tbusy = 1'b0;
    else begin
      if (en_write_show_pic) begin
        if (tbusy) viol++;
        held = show_pic_data;
        wlog.push_back(show_pic_data);
        tbusy = 1'b1;
      end else if (tbusy && (show_pic_data !== held)) viol++;
      if (fifo_rdEn) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        if (tbusy) viol++;
      end
      if (frame_done) fd_cnt++;
      if (frame_err) begin
        fe_cnt++;
        err_cyc = cyc;
      end
      if (frame_done && frame_err) viol++;
      if (wr_done) tbusy = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b);
    fmem[wp % 1024] = b;
    wp = wp + 1;
  endtask

  task automatic push_hdr(input logic [15:0] xs, input logic [15:0] ys, input logic [15:0] w, input logic [15:0] h);
    push(8'h55); push(8'hAA);
    push(xs[15:8]); push(xs[7:0]);
    push(ys[15:8]); push(ys[7:0]);
    push(w[15:8]);  push(w[7:0]);
    push(h[15:8]);  push(h[7:0]);
  endtask

  task automatic wait_evt(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (fd_cnt + fe_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    int p0;
    repeat (3) @(negedge sys_clk);
    n_cmp++; if (fifo_rdEn !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rdEn: got %b expected 0", fifo_rdEn); end
    n_cmp++; if (show_pic_data !== 9'h000) begin n_fail++; $display("[TB] FAIL rst_data: got %h expected 000", show_pic_data); end
    n_cmp++; if (en_write_show_pic !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_en: got %b expected 0", en_write_show_pic); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b expected 0", frame_done); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_err: got %b expected 0", frame_err); end
    sys_rst_n = 1'b1;
    p0 = pop_cnt;
    push(8'h00); push(8'h11);
    repeat (20) @(negedge sys_clk);
    n_cmp++; if (pop_cnt != p0) begin n_fail++; $display("[TB] FAIL idle_no_pop: got %0d pops expected 0", pop_cnt - p0); end
    init_done = 1'b1;
    repeat (12) @(negedge sys_clk);
    n_cmp++; if (pop_cnt - p0 != 2) begin n_fail++; $display("[TB] FAIL hunt_pops: got %0d expected 2", pop_cnt - p0); end
    n_cmp++; if (wlog.size() != 0) begin n_fail++; $display("[TB] FAIL junk_writes: got %0d expected 0", wlog.size()); end
  endtask

  task automatic test_basic_frame();
    logic [8:0] exp [15];
    int b, fd0, fe0;
    bit ok;
    exp = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10B, 9'h02B, 9'h100, 9'h114, 9'h100, 9'h114, 9'h02C,
            9'h112, 9'h134, 9'h156, 9'h178};
    @(negedge sys_clk);
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    push_hdr(16'd10, 16'd20, 16'd2, 16'd1);
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    wait_evt(fd0 + fe0 + 1, 2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL basic_wait: got timeout expected frame_done"); end
    n_cmp++; if (wlog.size() - b != 15) begin n_fail++; $display("[TB] FAIL basic_nwords: got %0d expected 15", wlog.size() - b); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (wlog[b + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL basic_word%0d: got %h expected %h", i, wlog[b + i], exp[i]); end
    end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("[TB] FAIL basic_done: got %0d expected 1", fd_cnt - fd0); end
    n_cmp++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("[TB] FAIL basic_err: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_zero_width();
    logic [8:0] exp [15];
    int b, fd0, fe0;
    bit ok;
    exp = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10B, 9'h02B, 9'h100, 9'h114, 9'h100, 9'h114, 9'h02C,
            9'h1AB, 9'h1CD, 9'h1EF, 9'h101};
    @(negedge sys_clk);
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    push_hdr(16'd10, 16'd20, 16'd0, 16'd1);
    push_hdr(16'd10, 16'd20, 16'd2, 16'd1);
    push(8'hAB); push(8'hCD); push(8'hEF); push(8'h01);
    wait_evt(fd0 + fe0 + 2, 2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL zw_wait: got timeout expected two events"); end
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("[TB] FAIL zw_err: got %0d expected 1", fe_cnt - fe0); end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("[TB] FAIL zw_done: got %0d expected 1", fd_cnt - fd0); end
    n_cmp++; if (wlog.size() - b != 15) begin n_fail++; $display("[TB] FAIL zw_nwords: got %0d expected 15", wlog.size() - b); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (wlog[b + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL zw_word%0d: got %h expected %h", i, wlog[b + i], exp[i]); end
    end
  endtask

  task automatic test_x_bound();
    logic [8:0] exp [15];
    int b, fd0, fe0;
    bit ok;
    exp = '{9'h02A, 9'h100, 9'h1EE, 9'h100, 9'h1EF, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02C,
            9'h101, 9'h102, 9'h103, 9'h104};
    @(negedge sys_clk);
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    push_hdr(16'd239, 16'd0, 16'd2, 16'd1);
    push_hdr(16'd238, 16'd0, 16'd2, 16'd1);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_evt(fd0 + fe0 + 2, 2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL xb_wait: got timeout expected two events"); end
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("[TB] FAIL xb_err: got %0d expected 1", fe_cnt - fe0); end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("[TB] FAIL xb_done: got %0d expected 1", fd_cnt - fd0); end
    n_cmp++; if (wlog.size() - b != 15) begin n_fail++; $display("[TB] FAIL xb_nwords: got %0d expected 15", wlog.size() - b); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (wlog[b + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL xb_word%0d: got %h expected %h", i, wlog[b + i], exp[i]); end
    end
  endtask

  task automatic test_resync();
    logic [8:0] exp [15];
    int b, fd0, fe0;
    bit ok;
    exp = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10B, 9'h02B, 9'h100, 9'h114, 9'h100, 9'h114, 9'h02C,
            9'h19A, 9'h1BC, 9'h1DE, 9'h1F0};
    @(negedge sys_clk);
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    push(8'h11); push(8'h55);
    push_hdr(16'd10, 16'd20, 16'd2, 16'd1);
    push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF0);
    wait_evt(fd0 + fe0 + 1, 2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL rs_wait: got timeout expected frame_done"); end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("[TB] FAIL rs_done: got %0d expected 1", fd_cnt - fd0); end
    n_cmp++; if (wlog.size() - b != 15) begin n_fail++; $display("[TB] FAIL rs_nwords: got %0d expected 15", wlog.size() - b); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (wlog[b + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL rs_word%0d: got %h expected %h", i, wlog[b + i], exp[i]); end
    end
  endtask

  task automatic test_timeout();
    int b, fd0, fe0;
    bit ok;
    @(negedge sys_clk);
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    push_hdr(16'd10, 16'd20, 16'd2, 16'd1);
    push(8'h12); push(8'h34);
    wait_evt(fd0 + fe0 + 1, 2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL to_wait: got no event expected frame_err"); end
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("[TB] FAIL to_err: got %0d expected 1", fe_cnt - fe0); end
    n_cmp++; if (fd_cnt - fd0 != 0) begin n_fail++; $display("[TB] FAIL to_done: got %0d expected 0", fd_cnt - fd0); end
    n_cmp++; if (err_cyc - last_pop_cyc != 50) begin n_fail++; $display("[TB] FAIL to_delay: got %0d cycles expected 50", err_cyc - last_pop_cyc); end
    n_cmp++; if (wlog.size() - b != 13) begin n_fail++; $display("[TB] FAIL to_nwords: got %0d expected 13", wlog.size() - b); end
    n_cmp++; if (wlog[b + 12] !== 9'h134) begin n_fail++; $display("[TB] FAIL to_lastword: got %h expected 134", wlog[b + 12]); end
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    push_hdr(16'd10, 16'd20, 16'd2, 16'd1);
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    wait_evt(fd0 + fe0 + 1, 2000, ok);
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("[TB] FAIL to_recover_done: got %0d expected 1", fd_cnt - fd0); end
    n_cmp++; if (wlog.size() - b != 15) begin n_fail++; $display("[TB] FAIL to_recover_nwords: got %0d expected 15", wlog.size() - b); end
    n_cmp++; if (wlog[b] !== 9'h02A) begin n_fail++; $display("[TB] FAIL to_recover_first: got %h expected 02A", wlog[b]); end
  endtask

  task automatic test_back_to_back_hold_and_reset();
    logic [8:0] exp [15];
    int b, fd0, fe0, v0;
    bit ok;
    exp = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10B, 9'h02B, 9'h100, 9'h114, 9'h100, 9'h114, 9'h02C,
            9'h112, 9'h134, 9'h156, 9'h178};
    @(negedge sys_clk);
    wr_lat = 20;
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt; v0 = viol;
    push_hdr(16'd10, 16'd20, 16'd2, 16'd1);
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    wait_evt(fd0 + fe0 + 1, 4000, ok);
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("[TB] FAIL hold_done: got %0d expected 1", fd_cnt - fd0); end
    n_cmp++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("[TB] FAIL hold_err: got %0d expected 0", fe_cnt - fe0); end
    n_cmp++; if (viol != v0) begin n_fail++; $display("[TB] FAIL hold_protocol: got %0d violations expected 0", viol - v0); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (wlog[b + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL hold_word%0d: got %h expected %h", i, wlog[b + i], exp[i]); end
    end
    wr_lat = 2;
    b = wlog.size();
    push_hdr(16'd0, 16'd0, 16'd4, 16'd1);
    for (int i = 1; i <= 8; i++) push(8'(i));
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (wlog.size() >= b + 13) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL rst_reach_pix: got %0d words expected 13", wlog.size() - b); end
    sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (show_pic_data !== 9'h000) begin n_fail++; $display("[TB] FAIL midrst_data: got %h expected 000", show_pic_data); end
    n_cmp++; if ({fifo_rdEn, en_write_show_pic, frame_done, frame_err} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL midrst_ctrl: got %b expected 0000", {fifo_rdEn, en_write_show_pic, frame_done, frame_err});
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    b = wlog.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    push_hdr(16'd10, 16'd20, 16'd2, 16'd1);
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    wait_evt(fd0 + fe0 + 1, 2000, ok);
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("[TB] FAIL postrst_done: got %0d expected 1", fd_cnt - fd0); end
    n_cmp++; if (wlog.size() - b != 15) begin n_fail++; $display("[TB] FAIL postrst_nwords: got %0d expected 15", wlog.size() - b); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (wlog[b + i] !== exp[i]) begin n_fail++; $display("[TB] FAIL postrst_word%0d: got %h expected %h", i, wlog[b + i], exp[i]); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_zero_width();
    test_x_bound();
    test_resync();
    test_timeout();
    test_back_to_back_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_pic_loader.md
Name: uart_pic_loader

Overview:
Sits between the UART receive FIFO and the LCD write path, replacing the free-running pixel feed with framed image transfers. It pops bytes from the FIFO and parses a frame header giving window position and size. It then issues the ST7789 window commands (CASET/RASET/RAMWR), and streams the pixel bytes to the LCD writer one 9-bit word at a time. It is gated by LCD init completion and flags malformed or stalled frames.

Parameters:
H_PIX, 240, panel width in pixels; the x window must end below this value.
V_PIX, 320, panel height in pixels; the y window must end below this value.
TIMEOUT_CYC, 24'd12_000_000, idle cycles allowed between bytes once a frame has started (1 s at 12 MHz).

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
init_done  in  1  LCD init complete; level signal
wr_done  in  1  one-cycle pulse from the LCD writer when the current word has been shifted out
fifo_empty  in  1  FIFO empty flag
fifo_data  in  8  FIFO read data; valid the cycle after fifo_rdEn
fifo_rdEn  out  1  one-cycle FIFO pop request
show_pic_data  out  9  word to the LCD writer; bit8 = 0 means command, bit8 = 1 means data
en_write_show_pic  out  1  one-cycle write strobe
frame_done  out  1  one-cycle pulse after the last pixel word's wr_done
frame_err  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Async reset: all outputs 0, show_pic_data = 9'h000, FSM in IDLE, all counters 0. Reset mid-frame discards the frame; the LCD is not re-initialised.
- Frame format: 0x55, 0xAA, then xs, ys, w, h, each 16-bit big-endian (only the low 9 bits are used), then w*h*2 pixel bytes.
- FIFO pop rule: fifo_rdEn pulses for 1 cycle only when !fifo_empty and the FSM needs a byte. The byte is captured on the next cycle. There is never more than one pop outstanding, and no pop occurs while a write is in flight.
- Write handshake: show_pic_data and en_write_show_pic update on the same edge. The strobe is high for exactly 1 cycle. show_pic_data is held until wr_done. The next strobe comes no earlier than the cycle after wr_done.
- FSM states:
  - IDLE: wait for init_done = 1, then go to HUNT0. Later deassertion of init_done is ignored.
  - HUNT0: pop bytes; 0x55 goes to HUNT1, anything else is discarded.
  - HUNT1: 0xAA goes to HDR. 0x55 stays in HUNT1. Anything else goes to HUNT0.
  - HDR: collect 8 bytes using a byte index 0..7.
  - CHECK (1 cycle):
    - xe = xs + w - 1 and ye = ys + h - 1, computed at 10-bit width so there is no wrap.
    - The frame is invalid if w == 0, h == 0, xe >= H_PIX or ye >= V_PIX.
    - Invalid: pulse frame_err and go to HUNT0.
    - Valid: load pix_cnt = w*h*2 (18-bit) and go to WIN.
  - WIN: send 11 words in order:
    - {0,0x2A}, {1,xs[15:8]}, {1,xs[7:0]}, {1,xe[15:8]}, {1,xe[7:0]}
    - {0,0x2B}, {1,ys hi}, {1,ys lo}, {1,ye hi}, {1,ye lo}
    - {0,0x2C}
    - Here xs/xe/ys/ye are zero-extended to 16 bits.
  - PIX: for each byte, pop it, send {1,byte}, wait for wr_done, then decrement pix_cnt. At pix_cnt == 0 after the final wr_done, pulse frame_done and go to HUNT0.
- Timeout: a counter runs in HDR and PIX while waiting on fifo_empty, and is cleared on each pop. On reaching TIMEOUT_CYC-1: pulse frame_err, go to HUNT0, and leave the window partially written. HUNT states never time out.
- A byte of 0x55 inside HDR or PIX is treated as data; there is no resync mid-frame.
- frame_done and frame_err never assert in the same cycle.
- Throughput: at most one byte per LCD word time. The FIFO absorbs UART bursts.

Test Plan:
1. Reset, init_done = 1. Push 55 AA 00 0A 00 14 00 02 00 01, then 4 pixel bytes 12 34 56 78 → 11 window words: 02A 100 10A 100 10B 02B 100 114 100 114 02C. Then 112 134 156 178, then one frame_done pulse.
2. Header with w = 0 → frame_err pulse, no strobe issued. A following valid frame is processed normally.
3. xs = 239, w = 2 → xe = 240 ≥ H_PIX → frame_err. xs = 238, w = 2 is accepted with xe word 0x1EF.
4. Garbage 11 55 55 AA then a valid header → the lock is taken on the second 0x55. Junk bytes produce no writes.
5. Stall the FIFO mid-PIX with TIMEOUT_CYC = 50 → frame_err exactly 50 cycles after the last pop, then back in HUNT0.
6. Hold wr_done low for 20 cycles → show_pic_data stays stable, the strobe is not repeated, and fifo_rdEn stays low until wr_done. Assert sys_rst_n low mid-PIX → all outputs 0 at once, and a new frame after release parses correctly.
